// File: rtl/riscv_pkg.sv
// Shared core constants and the second-level carry-lookahead helper used by
// the datapath adder.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int CLA_GROUP  = 4;
  localparam int CLA_GROUPS = XLEN / CLA_GROUP;

  // Each group carry is an independent sum-of-products over the group G/P
  // terms and the carry-in, so no carry waits on a neighbouring group carry.
  function automatic logic [CLA_GROUPS-1:0] group_carries(
    input logic [CLA_GROUPS-1:0] g,
    input logic [CLA_GROUPS-1:0] p,
    input logic                  cin
  );
    logic [CLA_GROUPS-1:0] c;
    logic                  term;
    c = '0;
    for (int k = 0; k < CLA_GROUPS; k++) begin
      term = cin;
      for (int m = 0; m < k; m++) term = term & p[m];
      c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = g[j];
        for (int m = j + 1; m < k; m++) term = term & p[m];
        c[k] = c[k] | term;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead block: produces the group sum plus group
// generate/propagate for the second-level lookahead unit.
module cla4
  import riscv_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] sum,
  output logic                 G,
  output logic                 P
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

  assign sum = p ^ c;

endmodule

// File: rtl/adder32.sv
// 32-bit two-level carry-lookahead adder with carry-in/out; sum and carry
// are registered once, giving one cycle of latency at full throughput.
module adder32
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            carryin,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] Y,
  output logic [XLEN-1:0] S,
  output logic            carryout
);

  logic [CLA_GROUPS-1:0] grp_g;
  logic [CLA_GROUPS-1:0] grp_p;
  logic [CLA_GROUPS-1:0] grp_c;
  logic [XLEN-1:0]       sum;

  logic [XLEN-1:0]       s_d, s_q;
  logic                  carryout_d, carryout_q;

  assign grp_c = group_carries(grp_g, grp_p, carryin);

  for (genvar i = 0; i < CLA_GROUPS; i++) begin : g_cla
    cla4 u_cla4 (
      .a   (X[i*CLA_GROUP +: CLA_GROUP]),
      .b   (Y[i*CLA_GROUP +: CLA_GROUP]),
      .cin (grp_c[i]),
      .sum (sum[i*CLA_GROUP +: CLA_GROUP]),
      .G   (grp_g[i]),
      .P   (grp_p[i])
    );
  end

  always_comb begin
    // NOTE: every always_comb output gets a value on every path, or a latch is inferred.
    s_d        = sum;
    carryout_d = grp_g[CLA_GROUPS-1]
               | (grp_p[CLA_GROUPS-1] & grp_c[CLA_GROUPS-1]);
  end

  // Reset is synchronous and overrides the operand capture on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for flops so all registers update together.
    if (rst) begin
      s_q        <= '0;
      carryout_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      carryout_q <= carryout_d;
    end
  end

  assign S        = s_q;
  assign carryout = carryout_q;

endmodule

// File: tb/tb_adder32.sv
// Scoreboard bench for adder32: the driver queues the expected 33-bit result
// per applied operand set; a monitor pops and compares after each edge.
module tb_adder32;

  logic        clk = 1'b0;
  logic        rst;
  logic        carryin;
  logic [31:0] X;
  logic [31:0] Y;
  logic [31:0] S;
  logic        carryout;

  typedef struct {
    logic [32:0] res;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   next_id  = 0;

  adder32 dut (
    .clk      (clk),
    .rst      (rst),
    .carryin  (carryin),
    .X        (X),
    .Y        (Y),
    .S        (S),
    .carryout (carryout)
  );

  always #5 clk = ~clk;

  task automatic check(input int id, input logic [32:0] act, input logic [32:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL result#%0d got carryout=%b S=%h, want carryout=%b S=%h",
               id, act[32], act[31:0], want[32], want[31:0]);
    end
  endtask

  // Drives one operand set during the low phase and queues what the
  // registered outputs must show after the next rising edge.
  task automatic apply(input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic r);
    exp_t e;
    @(negedge clk);
    X       = x;
    Y       = y;
    carryin = ci;
    rst     = r;
    e.res   = r ? 33'd0 : ({1'b0, x} + {1'b0, y} + {32'd0, ci});
    e.id    = next_id++;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.id, {carryout, S}, e.res);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : driver
    rst = 1'b1; carryin = 1'b0; X = '0; Y = '0;

    // Reset held two edges, then release
    apply(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    apply(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    apply(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);

    apply(32'h0, 32'h0, 1'b0, 1'b0);
    apply(32'h1, 32'h1, 1'b0, 1'b0);
    apply(32'h0, 32'h1, 1'b0, 1'b0);

    apply(32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0);
    apply(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    apply(32'h7FFF_FFFF, 32'h0,         1'b1, 1'b0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++)
      apply($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);

    // Reset edge sandwiched between two operand sets
    apply(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    apply(32'hCAFE_0000, 32'h0000_BABE, 1'b0, 1'b1);
    apply(32'hCAFE_0000, 32'h0000_BABE, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
